tc_ram_dma: RTL
===============

// Module: tc_ram_dma
// PURPOSE
//  Initiator side of the byte-RAM port: drives load/save/address/in of a 256x8 RAM and consumes its out.
//  Executes block commands (FILL, COPY, SUM) issued over a valid/ready command port.
//  Sits between the CPU/control logic and one RAM instance, so bulk transfers need no per-byte CPU work.
// PARAMETERS
//  ADDR_W  8  RAM address width; address arithmetic wraps mod 2^ADDR_W
//  DATA_W  8  RAM data width; checksum is mod 2^DATA_W
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst          in   1       reset, asynchronous, active-high
//  cmd_valid    in   1       command offered
//  cmd_ready    out  1       high only in IDLE; command accepted when valid&&ready at posedge
//  cmd_op       in   2       0=FILL 1=COPY 2=SUM 3=reserved (accepted, completes as len 0)
//  cmd_src      in   ADDR_W  source start address (COPY, SUM)
//  cmd_dst      in   ADDR_W  destination start address (FILL, COPY)
//  cmd_len      in   ADDR_W  byte count; 0 = no RAM access
//  cmd_data     in   DATA_W  fill value (FILL)
//  busy         out  1       high from accept until the DONE cycle ends
//  done         out  1       one-cycle pulse in the DONE state
//  result       out  DATA_W  SUM checksum; cleared on every accept; held after done
//  err          out  1       sticky verify mismatch; cleared on accept
//  ram_load     out  1       RAM read enable
//  ram_save     out  1       RAM write enable (RAM writes on negedge of the same cycle)
//  ram_address  out  ADDR_W  RAM address
//  ram_in       out  DATA_W  write data to RAM
//  ram_out      in   DATA_W  combinational read data from RAM
// BEHAVIOUR
//  Reset (any time, incl. mid-command): state=IDLE, all outputs 0 except cmd_ready=1; command lost.
//  All ram_* outputs are registered; never ram_load and ram_save high together.
//  States: IDLE, RD, WR, VF, DONE.
//   IDLE: on accept latch src/dst/len/data/op, clear result and err; len==0 or op==3 -> DONE, FILL -> WR, COPY/SUM -> RD.
//   RD: ram_load=1, ram_address=src; ram_out captured at closing posedge; src++.
//       SUM: result+=ram_out, len--, len==0 -> DONE else RD.  COPY -> WR.
//   WR: ram_save=1, ram_address=dst, ram_in=fill value (FILL) or captured byte (COPY); dst++; len--.
//       Next: VF if VERIFY enabled, else len==0 -> DONE, else FILL->WR, COPY->RD.
//   DONE: done=1, busy=1 for exactly one cycle -> IDLE.
//  Cost: FILL N = N cycles, COPY N = 2N, SUM N = N (3N / 2N with verify), plus one DONE cycle.
//  Addresses wrap 0xFF->0x00 (2^ADDR_W-1 -> 0); counters never saturate.
//  Overlapping COPY is strictly ascending byte-by-byte; dst in (src, src+len) replicates data (defined, not an error).
//  cmd_valid while busy is ignored (ready=0); no queueing.
// CONFIGURATION
//  TC_RAM_DMA_VERIFY_EN defined: after each WR, VF cycle: ram_load=1 at same address;
//   ram_out != written byte sets err; continuation as WR above.
//  Undefined: no VF state, no extra cycle, err tied 0.
// STRUCTURE
//  Package tc_ram_dma_pkg: op encodings (OP_FILL/OP_COPY/OP_SUM), state enum, ADDR_W/DATA_W defaults.
//  Sub-module tc_ram_dma_agen: src/dst/len counters with load, increment, wrap and len==0 flag.
//  FSM, data capture and checksum stay in tc_ram_dma.
// TESTING
//  FILL dst=0x10 len=4 data=0xA5 -> saves at 0x10..0x13 on 4 consecutive cycles, done 1 cycle later, RAM holds A5.
//  COPY src=0xFE dst=0x20 len=4 -> reads FE,FF,00,01 alternate with writes 20..23; done at cycle 9 after accept.
//  SUM src=0x00 len=3 over RAM {0x80,0x90,0x05} -> result=0x15 (mod 256), done after 3 read cycles.
//  len=0 any op -> no ram_load/ram_save, done the cycle after accept, result=0.
//  rst asserted mid-COPY at byte 2 -> ram_* immediately 0, cmd_ready=1, later command runs normally.
//  VERIFY_EN: force RAM mismatch on one FILL byte -> err=1 sticky through done, cleared on next accept.

Source files
------------

// File: rtl/tc_ram_dma_pkg.sv
// Shared definitions for the tc_ram_dma block-transfer engine.
// Command opcodes, FSM state encoding and default bus widths.
package tc_ram_dma_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_FILL = 2'd0,
    OP_COPY = 2'd1,
    OP_SUM  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_VF   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/tc_ram_dma_agen.sv
// Address/length generator for tc_ram_dma.
// Holds the source pointer, destination pointer and remaining byte count.
// Pointers wrap modulo 2^ADDR_W; the count never saturates.
module tc_ram_dma_agen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] src_init,
  input  logic [ADDR_W-1:0] dst_init,
  input  logic [ADDR_W-1:0] len_init,
  input  logic              src_inc,
  input  logic              dst_inc,
  input  logic              len_dec,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [ADDR_W-1:0] src_next,
  output logic [ADDR_W-1:0] dst_next,
  output logic              len_zero,
  output logic              len_last
);

  logic [ADDR_W-1:0] len;

  assign src_next = src + ADDR_W'(1);
  assign dst_next = dst + ADDR_W'(1);
  assign len_zero = (len == '0);
  assign len_last = (len == ADDR_W'(1));

  // Load all three counters on command accept, otherwise step them as the FSM requests.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use <= so every reader in this clock sees the pre-edge value.
    if (rst) begin
      src <= '0;
      dst <= '0;
      len <= '0;
    end else if (load) begin
      src <= src_init;
      dst <= dst_init;
      len <= len_init;
    end else begin
      if (src_inc) src <= src_next;
      if (dst_inc) dst <= dst_next;
      if (len_dec) len <= len - ADDR_W'(1);
    end
  end

endmodule

// File: rtl/tc_ram_dma.sv
// tc_ram_dma: initiator for a 256x8 byte RAM executing FILL / COPY / SUM
// block commands received over a valid/ready port. All RAM strobes are
// registered. Optional read-back verify after each write is enabled by
// defining TC_RAM_DMA_VERIFY_EN.
module tc_ram_dma
  import tc_ram_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              err,
  output logic              ram_load,
  output logic              ram_save,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

`ifdef TC_RAM_DMA_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  state_e            state;
  op_e               op_q;
  logic [DATA_W-1:0] data_q;     // fill value, or the byte just read for COPY

  logic              accept;
  logic [ADDR_W-1:0] src, dst, src_next, dst_next;
  logic              len_zero, len_last;

  // Continuation after a write (or after its verify read): in VF the counters
  // have already stepped, so the "last byte" test and next dst differ.
  logic              cont_last;
  logic [ADDR_W-1:0] cont_dst;

  assign accept    = cmd_valid && cmd_ready;
  assign cont_last = (state == ST_VF) ? len_zero : len_last;
  assign cont_dst  = (state == ST_VF) ? dst : dst_next;

  tc_ram_dma_agen #(.ADDR_W(ADDR_W)) u_agen (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .src_init (cmd_src),
    .dst_init (cmd_dst),
    .len_init (cmd_len),
    .src_inc  (state == ST_RD),
    .dst_inc  (state == ST_WR),
    .len_dec  ((state == ST_WR) || ((state == ST_RD) && (op_q == OP_SUM))),
    .src      (src),
    .dst      (dst),
    .src_next (src_next),
    .dst_next (dst_next),
    .len_zero (len_zero),
    .len_last (len_last)
  );

  // Command FSM: sequences RAM accesses and registers every output it drives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= OP_FILL;
      data_q      <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      ram_load    <= 1'b0;
      ram_save    <= 1'b0;
      ram_address <= '0;
      ram_in      <= '0;
    end else begin
      // NOTE: strobes default to 0 each cycle; only the branch entering an access raises one.
      ram_load    <= 1'b0;
      ram_save    <= 1'b0;
      ram_address <= '0;
      ram_in      <= '0;
      done        <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q      <= op_e'(cmd_op);
            data_q    <= cmd_data;
            result    <= '0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            if ((cmd_len == '0) || (cmd_op == OP_RSVD)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (cmd_op == OP_FILL) begin
              state       <= ST_WR;
              ram_save    <= 1'b1;
              ram_address <= cmd_dst;
              ram_in      <= cmd_data;
            end else begin
              state       <= ST_RD;
              ram_load    <= 1'b1;
              ram_address <= cmd_src;
            end
          end
        end

        ST_RD: begin
          if (op_q == OP_SUM) begin
            result <= result + ram_out;
            if (len_last) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              ram_load    <= 1'b1;
              ram_address <= src_next;
            end
          end else begin
            data_q      <= ram_out;
            state       <= ST_WR;
            ram_save    <= 1'b1;
            ram_address <= dst;
            ram_in      <= ram_out;
          end
        end

        ST_WR, ST_VF: begin
          if (VERIFY && (state == ST_WR)) begin
            state       <= ST_VF;
            ram_load    <= 1'b1;
            ram_address <= ram_address;
          end else if (cont_last) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (op_q == OP_FILL) begin
            state       <= ST_WR;
            ram_save    <= 1'b1;
            ram_address <= cont_dst;
            ram_in      <= data_q;
          end else begin
            state       <= ST_RD;
            ram_load    <= 1'b1;
            ram_address <= src;
          end
        end

        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef TC_RAM_DMA_VERIFY_EN
  // Sticky verify flag: set on read-back mismatch, cleared by the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    err <= 1'b0;
    else if (accept)                            err <= 1'b0;
    else if ((state == ST_VF) && (ram_out != data_q)) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
